boss_chase_ctrl: RTL and testbench

Multi-cycle breadth-first path-finding controller that computes the boss's next single-cell step toward the player on the 40x40 maze grid. It sits between the stage logic and the boss position register. On each movement tick the stage logic pulses `start`. The block then owns the map-row ROM port, sweeps the grid with a FIFO queue and a per-cell direction memory, and returns the first step of a shortest path. It replaces a purely combinational search with a sequenced, bounded-latency engine.

---
 rtl/boss_chase_if.sv | 41 ++++
 rtl/boss_chase_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_boss_chase_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boss_chase_if.sv
// boss_chase_if: stage-logic request/response and map-ROM signals for boss_chase_ctrl.
// Optional feature macro: BOSS_CHASE_STATS_EN adds the cells_visited counter output.
interface boss_chase_if #(
    parameter int unsigned GRID_W = 40
`ifdef BOSS_CHASE_STATS_EN
    , parameter int unsigned IDX_W = 11
`endif
);
    logic              start;
    logic [5:0]        boss_cx;
    logic [5:0]        boss_cy;
    logic [5:0]        player_cx;
    logic [5:0]        player_cy;
    logic [5:0]        map_addr;
    logic [GRID_W-1:0] map_row;
    logic              busy;
    logic              done;
    logic              found;
    logic [2:0]        step_dir;
`ifdef BOSS_CHASE_STATS_EN
    logic [IDX_W-1:0]  cells_visited;
`endif

    // Stage logic / ROM side
    modport master (
        output start, boss_cx, boss_cy, player_cx, player_cy, map_row,
        input  map_addr, busy, done, found, step_dir
`ifdef BOSS_CHASE_STATS_EN
        , input cells_visited
`endif
    );

    // Path-finding controller side
    modport slave (
        input  start, boss_cx, boss_cy, player_cx, player_cy, map_row,
        output map_addr, busy, done, found, step_dir
`ifdef BOSS_CHASE_STATS_EN
        , output cells_visited
`endif
    );
endinterface

// File: rtl/boss_chase_ctrl.sv
// boss_chase_ctrl: sequenced BFS that returns the boss's first step toward the player.
// Optional feature macro: BOSS_CHASE_STATS_EN adds cells_visited (enqueue count).
module boss_chase_ctrl #(
    parameter int unsigned GRID_W = 40,
    parameter int unsigned GRID_H = 40,
    parameter int unsigned IDX_W  = 11
) (
    input  logic        clk,
    input  logic        rst,
    boss_chase_if.slave bus
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned CW    = 6;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEED, S_POP, S_NREQ, S_NCHK, S_DONE} state_t;

    typedef struct packed {
        logic [2:0]       dir;
        logic [IDX_W-1:0] idx;
    } qent_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d, rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    bx_q, bx_d, by_q, by_d, px_q, px_d, py_q, py_d;
    logic [CW-1:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d, nb_x_q, nb_x_d, nb_y_q, nb_y_d;
    logic [2:0]       cur_dir_q, cur_dir_d, res_dir_q, res_dir_d, step_dir_q, step_dir_d;
    logic [1:0]       nb_k_q, nb_k_d;
    logic             seed_q, seed_d, nb_ok_q, nb_ok_d, res_found_q, res_found_d;
    logic             busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic [CW-1:0]    map_addr_q, map_addr_d;
`ifdef BOSS_CHASE_STATS_EN
    logic [IDX_W-1:0] cnt_q, cnt_d;
`endif

    // Direction memory (0 = unvisited) and BFS queue; contents are not reset
    logic [2:0]       dir_mem [CELLS];
    qent_t            q_mem   [CELLS];
    logic [2:0]       dir_rd_q;

    logic             load_nb, dir_we, q_we, hit;
    logic [IDX_W-1:0] dir_waddr, nb_idx_c, boss_idx_c;
    logic [2:0]       dir_wdata, dir_use_c;
    qent_t            q_wdata, pop_ent;
    logic [CW-1:0]    col_sel_c;

    assign nb_idx_c   = IDX_W'(nb_y_q * GRID_W + nb_x_q);
    assign boss_idx_c = IDX_W'(by_q * GRID_W + bx_q);
    assign col_sel_c  = CW'(GRID_W - 1) - nb_x_q;
    assign dir_use_c  = seed_q ? (3'(nb_k_q) + 3'd1) : cur_dir_q;

    // Next-state, datapath and output logic
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        bx_d        = bx_q;
        by_d        = by_q;
        px_d        = px_q;
        py_d        = py_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_dir_d   = cur_dir_q;
        seed_d      = seed_q;
        nb_k_d      = nb_k_q;
        nb_x_d      = nb_x_q;
        nb_y_d      = nb_y_q;
        nb_ok_d     = nb_ok_q;
        res_found_d = res_found_q;
        res_dir_d   = res_dir_q;
        map_addr_d  = map_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        step_dir_d  = step_dir_q;
`ifdef BOSS_CHASE_STATS_EN
        cnt_d       = cnt_q;
`endif
        load_nb     = 1'b0;
        hit         = 1'b0;
        dir_we      = 1'b0;
        dir_waddr   = '0;
        dir_wdata   = '0;
        q_we        = 1'b0;
        q_wdata     = '0;
        pop_ent     = q_mem[rd_q];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bx_d      = bus.boss_cx;
                    by_d      = bus.boss_cy;
                    px_d      = bus.player_cx;
                    py_d      = bus.player_cy;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
`ifdef BOSS_CHASE_STATS_EN
                    cnt_d     = '0;
`endif
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dir_we    = 1'b1;
                dir_waddr = clr_cnt_q;
                if (clr_cnt_q == IDX_W'(CELLS - 1)) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = S_SEED;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            S_SEED: begin
                if (bx_q == px_q && by_q == py_q) begin
                    res_found_d = 1'b1;
                    res_dir_d   = 3'd0;
                    state_d     = S_DONE;
                end else begin
                    // Any nonzero code marks the boss cell visited
                    dir_we    = 1'b1;
                    dir_waddr = boss_idx_c;
                    dir_wdata = 3'd7;
                    cur_x_d   = bx_q;
                    cur_y_d   = by_q;
                    seed_d    = 1'b1;
                    nb_k_d    = 2'd0;
                    load_nb   = 1'b1;
                    state_d   = S_NREQ;
                end
            end
            S_POP: begin
                if (rd_q == wr_q) begin
                    res_found_d = 1'b0;
                    res_dir_d   = 3'd0;
                    state_d     = S_DONE;
                end else begin
                    cur_x_d   = CW'(pop_ent.idx % GRID_W);
                    cur_y_d   = CW'(pop_ent.idx / GRID_W);
                    cur_dir_d = pop_ent.dir;
                    seed_d    = 1'b0;
                    rd_d      = rd_q + IDX_W'(1);
                    nb_k_d    = 2'd0;
                    load_nb   = 1'b1;
                    state_d   = S_NREQ;
                end
            end
            S_NREQ: begin
                if (nb_ok_q) begin
                    state_d = S_NCHK;
                end else if (nb_k_q == 2'd3) begin
                    state_d = S_POP;
                end else begin
                    nb_k_d  = nb_k_q + 2'd1;
                    load_nb = 1'b1;
                end
            end
            S_NCHK: begin
                if (!bus.map_row[col_sel_c] && (dir_rd_q == 3'd0)) begin
                    dir_we      = 1'b1;
                    dir_waddr   = nb_idx_c;
                    dir_wdata   = dir_use_c;
                    q_we        = 1'b1;
                    q_wdata.dir = dir_use_c;
                    q_wdata.idx = nb_idx_c;
                    wr_d        = wr_q + IDX_W'(1);
`ifdef BOSS_CHASE_STATS_EN
                    cnt_d       = cnt_q + IDX_W'(1);
`endif
                    if (nb_x_q == px_q && nb_y_q == py_q) begin
                        hit         = 1'b1;
                        res_found_d = 1'b1;
                        res_dir_d   = dir_use_c;
                        state_d     = S_DONE;
                    end
                end
                if (!hit) begin
                    if (nb_k_q == 2'd3) begin
                        state_d = S_POP;
                    end else begin
                        nb_k_d  = nb_k_q + 2'd1;
                        load_nb = 1'b1;
                        state_d = S_NREQ;
                    end
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                found_d    = res_found_q;
                step_dir_d = res_dir_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Neighbor k (UP, LEFT, DOWN, RIGHT) of the current cell; ROM row presented ahead of NREQ
        if (load_nb) begin
            nb_ok_d = 1'b1;
            nb_x_d  = cur_x_d;
            nb_y_d  = cur_y_d;
            case (nb_k_d)
                2'd0: if (cur_y_d == '0) nb_ok_d = 1'b0; else nb_y_d = cur_y_d - CW'(1);
                2'd1: if (cur_x_d == '0) nb_ok_d = 1'b0; else nb_x_d = cur_x_d - CW'(1);
                2'd2: if (cur_y_d >= CW'(GRID_H - 1)) nb_ok_d = 1'b0; else nb_y_d = cur_y_d + CW'(1);
                default: if (cur_x_d >= CW'(GRID_W - 1)) nb_ok_d = 1'b0; else nb_x_d = cur_x_d + CW'(1);
            endcase
            if (nb_ok_d) map_addr_d = nb_y_d;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_dir_q   <= '0;
            seed_q      <= 1'b0;
            nb_k_q      <= '0;
            nb_x_q      <= '0;
            nb_y_q      <= '0;
            nb_ok_q     <= 1'b0;
            res_found_q <= 1'b0;
            res_dir_q   <= '0;
            map_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            step_dir_q  <= '0;
`ifdef BOSS_CHASE_STATS_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_dir_q   <= cur_dir_d;
            seed_q      <= seed_d;
            nb_k_q      <= nb_k_d;
            nb_x_q      <= nb_x_d;
            nb_y_q      <= nb_y_d;
            nb_ok_q     <= nb_ok_d;
            res_found_q <= res_found_d;
            res_dir_q   <= res_dir_d;
            map_addr_q  <= map_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            step_dir_q  <= step_dir_d;
`ifdef BOSS_CHASE_STATS_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Memory write ports and registered direction-memory read issued in NREQ
    always_ff @(posedge clk) begin
        if (dir_we) dir_mem[dir_waddr] <= dir_wdata;
        if (q_we) q_mem[wr_q] <= q_wdata;
        if (state_q == S_NREQ) dir_rd_q <= dir_mem[nb_idx_c];
    end

    assign bus.map_addr = map_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.found    = found_q;
    assign bus.step_dir = step_dir_q;
`ifdef BOSS_CHASE_STATS_EN
    assign bus.cells_visited = cnt_q;
`endif
endmodule

// File: tb/tb_boss_chase_ctrl.sv
// tb_boss_chase_ctrl: table vectors, random mazes vs a BFS reference model, reset/robustness sequences.
module tb_boss_chase_ctrl;
    localparam int GW    = 40;
    localparam int GH    = 40;
    localparam int CELLS = GW * GH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boss_chase_if #(.GRID_W(GW)) bus ();
    boss_chase_ctrl #(.GRID_W(GW), .GRID_H(GH), .IDX_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));

    bit            wall [GH][GW];
    logic [GW-1:0] rows [64];
    int            n_vec = 0;
    int            n_err = 0;
    int            done_cnt = 0;

    // Map ROM with one-cycle read latency
    always @(posedge clk) bus.map_row <= rows[bus.map_addr];

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    typedef struct {
        int kind; int bx; int by; int px; int py; int ef; int ed; int elat;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // 0 bordered, 1 bordered + wall (1,2), 2 small pocket with walled player (10,10), 3 open, else random
    task automatic set_map(input int kind);
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                bit b;
                bit w;
                b = (x == 0 || y == 0 || x == GW - 1 || y == GH - 1);
                case (kind)
                    0: w = b;
                    1: w = b || (x == 1 && y == 2);
                    2: w = !(x >= 8 && x <= 12 && y >= 8 && y <= 12) ||
                           (x == 10 && y == 9) || (x == 9 && y == 10) ||
                           (x == 11 && y == 10) || (x == 10 && y == 11);
                    3: w = 1'b0;
                    default: w = ($urandom_range(0, 99) < 55);
                endcase
                wall[y][x] = w;
            end
        end
        for (int r = 0; r < 64; r++) rows[r] = '0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (wall[y][x]) rows[y][GW-1-x] = 1'b1;
    endtask

    // Breadth-first search on the wall array; also totals the cycle cost of each phase
    task automatic model(input int bx, input int by, input int px, input int py,
                         output bit mf, output int md, output int mlat, output int menq);
        bit vis [CELLS];
        int qx[$];
        int qy[$];
        int qd[$];
        int dx [4] = '{0, -1, 0, 1};
        int dy [4] = '{-1, 0, 1, 0};
        int cx, cy, cd, nx, ny, nd;
        bit seed, fin;
        mf = 0; md = 0; menq = 0;
        mlat = 1 + CELLS + 1;
        fin = 0;
        if (bx == px && by == py) begin
            mf = 1; mlat += 1; fin = 1;
        end
        for (int i = 0; i < CELLS; i++) vis[i] = 0;
        vis[by * GW + bx] = 1;
        cx = bx; cy = by; cd = 0; seed = 1;
        while (!fin) begin
            for (int k = 0; k < 4; k++) begin
                if (!fin) begin
                    nx = cx + dx[k];
                    ny = cy + dy[k];
                    if (nx < 0 || ny < 0 || nx >= GW || ny >= GH) begin
                        mlat += 1;
                    end else begin
                        mlat += 2;
                        if (!wall[ny][nx] && !vis[ny * GW + nx]) begin
                            nd = seed ? k + 1 : cd;
                            vis[ny * GW + nx] = 1;
                            qx.push_back(nx); qy.push_back(ny); qd.push_back(nd);
                            menq++;
                            if (nx == px && ny == py) begin
                                mf = 1; md = nd; mlat += 1; fin = 1;
                            end
                        end
                    end
                end
            end
            if (!fin) begin
                seed = 0;
                mlat += 1;
                if (qx.size() == 0) begin
                    mlat += 1; fin = 1;
                end else begin
                    cx = qx.pop_front(); cy = qy.pop_front(); cd = qd.pop_front();
                end
            end
        end
    endtask

    task automatic run_search(input string tag, input int bx, input int by, input int px,
                              input int py, input bit extra,
                              output int f, output int d, output int lat);
        bit mf;
        int md, mlat, menq;
        bit seen;
        model(bx, by, px, py, mf, md, mlat, menq);
        @(negedge clk);
        bus.boss_cx   = 6'(bx);
        bus.boss_cy   = 6'(by);
        bus.player_cx = 6'(px);
        bus.player_cy = 6'(py);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        chk({tag, ".busy_rise"}, int'(bus.busy), 1);
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        while (!seen && lat < 17000) begin
            @(posedge clk); #1;
            lat++;
            if (extra && (lat == 100 || lat == 1605)) begin
                bus.start     = 1'b1;
                bus.player_cx = 6'(bx);
                bus.player_cy = 6'(by);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) seen = 1;
        end
        bus.start = 1'b0;
        f = int'(bus.found);
        d = int'(bus.step_dir);
        chk({tag, ".done_seen"}, int'(seen), 1);
        chk({tag, ".busy_at_done"}, int'(bus.busy), 0);
        chk({tag, ".found"}, f, int'(mf));
        chk({tag, ".step_dir"}, d, md);
        chk({tag, ".latency"}, lat, mlat);
`ifdef BOSS_CHASE_STATS_EN
        chk({tag, ".cells_visited"}, int'(bus.cells_visited), menq);
`endif
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, int'(bus.done), 0);
        chk({tag, ".found_hold"}, int'(bus.found), int'(mf));
        chk({tag, ".dir_hold"}, int'(bus.step_dir), md);
    endtask

    initial begin
        int f, d, l, d0, bx, by, px, py;
        tbl[0] = '{0, 1, 1, 3, 1, 1, 4, 0};
        tbl[1] = '{1, 1, 1, 1, 3, 1, 4, 0};
        tbl[2] = '{0, 5, 5, 5, 5, 1, 0, 1603};
        tbl[3] = '{2, 8, 8, 10, 10, 0, 0, 0};
        tbl[4] = '{0, 5, 5, 5, 2, 1, 1, 0};
        tbl[5] = '{0, 5, 5, 2, 5, 1, 2, 0};
        tbl[6] = '{0, 5, 5, 5, 9, 1, 3, 0};
        tbl[7] = '{2, 8, 8, 7, 7, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 1, 1, 1, 4, 0};
        tbl[9] = '{3, 0, 0, 0, 1, 1, 3, 1607};

        bus.start = 1'b0;
        bus.boss_cx = '0; bus.boss_cy = '0; bus.player_cx = '0; bus.player_cy = '0;
        set_map(0);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.done", int'(bus.done), 0);
        chk("reset.found", int'(bus.found), 0);
        chk("reset.step_dir", int'(bus.step_dir), 0);
        chk("reset.map_addr", int'(bus.map_addr), 0);
`ifdef BOSS_CHASE_STATS_EN
        chk("reset.cells_visited", int'(bus.cells_visited), 0);
`endif
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_map(tbl[i].kind);
            run_search($sformatf("vec%0d", i), tbl[i].bx, tbl[i].by, tbl[i].px, tbl[i].py, 1'b0, f, d, l);
            chk($sformatf("vec%0d.tbl_found", i), f, tbl[i].ef);
            chk($sformatf("vec%0d.tbl_dir", i), d, tbl[i].ed);
            if (tbl[i].elat != 0) chk($sformatf("vec%0d.tbl_latency", i), l, tbl[i].elat);
        end

        for (int i = 0; i < 12; i++) begin
            set_map(4);
            bx = $urandom_range(0, GW - 1);
            by = $urandom_range(0, GH - 1);
            if (i % 2 == 1) begin
                px = bx + $urandom_range(0, 4) - 2;
                py = by + $urandom_range(0, 4) - 2;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                if (px > GW - 1) px = GW - 1;
                if (py > GH - 1) py = GH - 1;
            end else begin
                px = $urandom_range(0, GW - 1);
                py = $urandom_range(0, GH - 1);
            end
            run_search($sformatf("rnd%0d", i), bx, by, px, py, 1'b0, f, d, l);
        end

        // Extra start pulses during CLEAR and during the sweep are ignored
        set_map(0);
        d0 = done_cnt;
        run_search("busy_start", 1, 1, 4, 4, 1'b1, f, d, l);
        repeat (30) @(posedge clk);
        chk("busy_start.done_count", done_cnt - d0, 1);

        // Reset while the first POP is active (seed's four neighbors finish at edge 1609)
        @(negedge clk);
        bus.boss_cx = 6'd1; bus.boss_cy = 6'd1; bus.player_cx = 6'd4; bus.player_cy = 6'd4;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        repeat (1609) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.done", int'(bus.done), 0);
        chk("midrst.found", int'(bus.found), 0);
        chk("midrst.step_dir", int'(bus.step_dir), 0);
        chk("midrst.map_addr", int'(bus.map_addr), 0);
`ifdef BOSS_CHASE_STATS_EN
        chk("midrst.cells_visited", int'(bus.cells_visited), 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_search("after_rst", 1, 1, 3, 1, 1'b0, f, d, l);
        chk("after_rst.tbl_dir", d, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
